// File: rtl/instr_fetch_unit.sv
// Program-memory fetch requester: issues word addresses, captures returned
// instructions and hands them to decode in order over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    input  logic [DATA_WIDTH-1:0] pm_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic                  skid_valid_q, skid_valid_d;

    logic       pop;
    logic       issue;
    logic [1:0] occ;
    logic [2:0] committed;

    // Handshake: a word transfers to decode on any rising edge where
    // instr_valid and instr_ready are both high; instr/instr_pc hold otherwise.
    assign pop       = instr_valid_q & instr_ready;
    assign occ       = {1'b0, instr_valid_q} + {1'b0, skid_valid_q};
    assign committed = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = redirect_valid | (committed < 3'd2);

    // When not issuing, the previous address is held and the memory output is ignored.
    always_comb begin
        if (rst)                 pm_addr = RESET_PC;
        else if (redirect_valid) pm_addr = redirect_addr;
        else if (issue)          pm_addr = fetch_pc_q;
        else                     pm_addr = last_addr_q;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        last_addr_d   = last_addr_q;
        inflight_d    = 1'b0;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        skid_data_d   = skid_data_q;
        skid_pc_d     = skid_pc_q;
        skid_valid_d  = skid_valid_q;

        if (issue) begin
            last_addr_d = pm_addr;
            fetch_pc_d  = pm_addr + ADDR_ONE;
            inflight_d  = 1'b1;
        end

        if (redirect_valid) begin
            // The word returning this cycle belongs to the old stream and is dropped.
            instr_valid_d = 1'b0;
            skid_valid_d  = 1'b0;
        end else begin
            if (pop) begin
                instr_valid_d = skid_valid_q;
                instr_d       = skid_data_q;
                instr_pc_d    = skid_pc_q;
                skid_valid_d  = 1'b0;
            end
            if (inflight_q) begin
                if (!instr_valid_d) begin
                    instr_d       = pm_data;
                    instr_pc_d    = last_addr_q;
                    instr_valid_d = 1'b1;
                end else begin
                    skid_data_d  = pm_data;
                    skid_pc_d    = last_addr_q;
                    skid_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            last_addr_q   <= RESET_PC;
            inflight_q    <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            skid_data_q   <= '0;
            skid_pc_q     <= '0;
            skid_valid_q  <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            last_addr_q   <= last_addr_d;
            inflight_q    <= inflight_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            skid_data_q   <= skid_data_d;
            skid_pc_q     <= skid_pc_d;
            skid_valid_q  <= skid_valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

    // Buffered plus in-flight words may never exceed the two storage slots.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, occ} + {2'b00, inflight_q}) <= 3'd2);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random
// ready/redirect/reset traffic against a stream-level reference model.
module tb_instr_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk;
    logic        rst;
    logic [15:0] pm_addr;
    logic [31:0] pm_data;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    instr_fetch_unit #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pm_addr       (pm_addr),
        .pm_data       (pm_data),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    // clock / memory model: word at address a is 0xA000_0000 + a, one-cycle latency
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pm_data = 32'h0;
    always @(posedge clk) pm_data <= 32'hA000_0000 + {16'h0000, pm_addr};

    int total = 0;
    int bad   = 0;

    // reference model state: the accepted stream is consecutive PCs from the last restart
    logic [15:0] exp_pc    = RESET_PC;
    logic [15:0] start_pc  = RESET_PC;
    int          since     = 1000;
    logic        prev_hold  = 1'b0;
    logic        prev_nogap = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] hold_instr = 32'h0;
    logic [15:0] hold_pc    = 16'h0;

    logic        obs_valid;
    logic [15:0] obs_pc;
    logic [31:0] obs_instr;
    logic [15:0] obs_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, sample just after, run the model.
    task automatic tick(input logic r, input logic rv, input logic [15:0] ra, input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_addr  = ra;
        instr_ready    = rdy;
        #1;
        obs_valid = instr_valid;
        obs_pc    = instr_pc;
        obs_instr = instr;
        obs_addr  = pm_addr;
        if (r) begin
            check("rst_addr", {16'h0, pm_addr}, {16'h0, RESET_PC});
            exp_pc     = RESET_PC;
            start_pc   = RESET_PC;
            since      = -1;
            prev_hold  = 1'b0;
            prev_nogap = 1'b0;
        end else begin
            if (since == 0) check("rst_clear", {31'h0, obs_valid}, 32'h0);
            if (since == 1) check("restart_gap", {31'h0, obs_valid}, 32'h0);
            if (since == 2) begin
                check("restart_valid", {31'h0, obs_valid}, 32'h1);
                check("restart_pc", {16'h0, obs_pc}, {16'h0, start_pc});
            end
            if (prev_hold) begin
                check("hold_valid", {31'h0, obs_valid}, 32'h1);
                check("hold_pc", {16'h0, obs_pc}, {16'h0, hold_pc});
                check("hold_instr", obs_instr, hold_instr);
            end
            if (prev_nogap) check("no_gap", {31'h0, obs_valid}, 32'h1);
            if (obs_valid === 1'b1 && rdy) begin
                check("pop_pc", {16'h0, obs_pc}, {16'h0, exp_pc});
                check("pop_instr", obs_instr, 32'hA000_0000 + {16'h0, exp_pc});
                exp_pc = exp_pc + 16'h1;
            end
            if (rv) begin
                check("redir_addr", {16'h0, pm_addr}, {16'h0, ra});
                exp_pc   = ra;
                start_pc = ra;
                since    = 0;
            end
            prev_hold  = (obs_valid === 1'b1) && !rdy && !rv;
            prev_nogap = (obs_valid === 1'b1) && rdy && prev_ready && !rv;
            hold_pc    = obs_pc;
            hold_instr = obs_instr;
        end
        prev_ready = rdy && !r;
        if (since < 1000) since++;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] wrap_pcs [4];
        logic        r, rv, rdy;
        logic [15:0] ra;
        int          rdy_pct;

        wrap_pcs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        rst = 1'b1; redirect_valid = 1'b0; redirect_addr = 16'h0; instr_ready = 1'b0;
        @(negedge clk);

        // 1: reset, streaming from RESET_PC
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 1);
            check("t1_valid", {31'h0, obs_valid}, 32'h1);
            check("t1_pc", {16'h0, obs_pc}, i);
        end

        // 2: stall while pc 4 is presented, then resume
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0);
            check("t2_stall_pc", {16'h0, obs_pc}, 32'h4);
            check("t2_issue_bound", {31'h0, obs_addr <= 16'h6}, 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 1);
            check("t2_resume_pc", {16'h0, obs_pc}, 4 + i);
        end

        // 3: redirect while stalled with the skid full
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 16'h0100, 0);
        tick(0, 0, 0, 0);
        check("t3_flush", {31'h0, obs_valid}, 32'h0);
        tick(0, 0, 0, 1);
        check("t3_first_pc", {16'h0, obs_pc}, 32'h0100);
        tick(0, 0, 0, 1);
        check("t3_second_pc", {16'h0, obs_pc}, 32'h0101);

        // 4: address wrap at the top of the space
        tick(0, 1, 16'hFFFE, 1);
        tick(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 1);
            check("t4_wrap_pc", {16'h0, obs_pc}, {16'h0, wrap_pcs[i]});
        end

        // 5: back-to-back redirects, only the last stream survives
        tick(0, 1, 16'h0300, 0);
        tick(0, 1, 16'h0200, 0);
        tick(0, 0, 0, 1);
        check("t5_gap", {31'h0, obs_valid}, 32'h0);
        tick(0, 0, 0, 1);
        check("t5_first_pc", {16'h0, obs_pc}, 32'h0200);
        tick(0, 0, 0, 1);
        check("t5_second_pc", {16'h0, obs_pc}, 32'h0201);

        // 6: one-cycle reset mid-stream with the skid full
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        check("t6_cleared", {31'h0, obs_valid}, 32'h0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        check("t6_restart_pc", {16'h0, obs_pc}, {16'h0, RESET_PC});

        // random traffic in phases of differing backpressure
        for (int p = 0; p < 4; p++) begin
            rdy_pct = (p == 0) ? 90 : (p == 1) ? 50 : (p == 2) ? 20 : 70;
            for (int i = 0; i < 600; i++) begin
                r   = ($urandom_range(0, 249) == 0);
                rv  = ($urandom_range(0, 19) == 0);
                ra  = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                  : 16'($urandom);
                rdy = ($urandom_range(0, 99) < rdy_pct);
                tick(r, rv, ra, rdy);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
